// File: rtl/game_pkg.sv
// Shared game-flow types and defaults; the overlay and LED logic import game_state_t from here.
package game_pkg;

  localparam int unsigned DEFAULT_NUM_LEVELS  = 3;
  localparam int unsigned DEFAULT_LEVEL_W     = 2;
  localparam int unsigned DEFAULT_START_LIVES = 3;
  localparam int unsigned DEFAULT_HOLD_CYCLES = 50_000_000;

  typedef enum logic [2:0] {
    ST_TITLE     = 3'd0,
    ST_PLAY      = 3'd1,
    ST_WIN_HOLD  = 3'd2,
    ST_LOSE_HOLD = 3'd3,
    ST_GAME_OVER = 3'd4,
    ST_COMPLETE  = 3'd5
  } game_state_t;

  function automatic logic is_hold(input game_state_t s);
    return (s == ST_WIN_HOLD) || (s == ST_LOSE_HOLD);
  endfunction

endpackage

// File: rtl/button_sync_edge.sv
// Two-flop synchronizer for a raw board button plus a registered one-cycle rising-edge pulse.
module button_sync_edge (
  input  logic vga_clock,
  input  logic reset,
  input  logic button,
  output logic pulse
);

  logic sync_1;
  logic sync_2;
  logic sync_2_d;

  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      sync_1   <= 1'b0;
      sync_2   <= 1'b0;
      sync_2_d <= 1'b0;
      pulse    <= 1'b0;
    end else begin
      sync_1   <= button;
      sync_2   <= sync_1;
      sync_2_d <= sync_2;
      pulse    <= sync_2 & ~sync_2_d;
    end
  end

endmodule

// File: rtl/game_flow_controller.sv
// Game sequencer: title/play/hold/end screens, live-level selection and per-level resets.
// Define GAME_LIVES_EN to keep a lives counter; without it every lost level ends the game.
module game_flow_controller
  import game_pkg::*;
#(
  parameter int unsigned NUM_LEVELS  = DEFAULT_NUM_LEVELS,
  parameter int unsigned LEVEL_W     = DEFAULT_LEVEL_W,
  parameter int unsigned START_LIVES = DEFAULT_START_LIVES,
  parameter int unsigned HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
  input  logic                  vga_clock,
  input  logic                  reset,
  input  logic                  start_button,
  input  logic                  level_win,
  input  logic                  level_lose,
  output logic [NUM_LEVELS-1:0] level_reset_n,
  output logic [LEVEL_W-1:0]    level_sel,
  output logic [2:0]            game_state,
  output logic [2:0]            lives,
  output logic                  hold_active
);

  localparam int unsigned HOLD_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(NUM_LEVELS - 1);

  if ((START_LIVES < 1) || (START_LIVES > 7) || (HOLD_CYCLES < 1) ||
      (NUM_LEVELS < 1) || (NUM_LEVELS > (1 << LEVEL_W))) begin : g_bad_params
    $error("game_flow_controller: illegal parameter combination");
  end

  game_state_t           state;
  game_state_t           state_d;
  logic [LEVEL_W-1:0]    level_sel_d;
  logic [HOLD_W-1:0]     hold_cnt;
  logic [HOLD_W-1:0]     hold_cnt_d;
  logic [NUM_LEVELS-1:0] level_reset_n_d;
  logic                  start_pulse;
  logic                  hold_done;

`ifdef GAME_LIVES_EN
  logic [2:0] lives_d;
`endif

  button_sync_edge u_start_sync (
    .vga_clock (vga_clock),
    .reset     (reset),
    .button    (start_button),
    .pulse     (start_pulse)
  );

  assign hold_done = (hold_cnt == '0);

  // Next-state, level index, hold counter and lives
  always_comb begin
    state_d     = state;
    level_sel_d = level_sel;
    hold_cnt_d  = hold_cnt;
`ifdef GAME_LIVES_EN
    lives_d     = lives;
`endif
    case (state)
      ST_TITLE: begin
        if (start_pulse) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (level_win) begin
          state_d    = ST_WIN_HOLD;
          hold_cnt_d = HOLD_LOAD;
        end else if (level_lose) begin
          state_d    = ST_LOSE_HOLD;
          hold_cnt_d = HOLD_LOAD;
`ifdef GAME_LIVES_EN
          if (lives != 3'd0) lives_d = lives - 3'd1;
`endif
        end
      end
      ST_WIN_HOLD: begin
        if (!hold_done) begin
          hold_cnt_d = hold_cnt - HOLD_W'(1);
        end else if (level_sel == LAST_LEVEL) begin
          state_d = ST_COMPLETE;
        end else begin
          state_d     = ST_PLAY;
          level_sel_d = level_sel + LEVEL_W'(1);
        end
      end
      ST_LOSE_HOLD: begin
        if (!hold_done) begin
          hold_cnt_d = hold_cnt - HOLD_W'(1);
        end else begin
`ifdef GAME_LIVES_EN
          state_d = (lives == 3'd0) ? ST_GAME_OVER : ST_TITLE;
`else
          state_d = ST_GAME_OVER;
`endif
        end
      end
      ST_GAME_OVER, ST_COMPLETE: begin
        if (start_pulse) begin
          state_d     = ST_TITLE;
          level_sel_d = '0;
`ifdef GAME_LIVES_EN
          lives_d     = 3'(START_LIVES);
`endif
        end
      end
      default: state_d = ST_TITLE;
    endcase
  end

  // Only the live level is released, and only while playing
  always_comb begin
    level_reset_n_d = '0;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      level_reset_n_d[i] = (state_d == ST_PLAY) && (level_sel_d == LEVEL_W'(i));
    end
  end

  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      state         <= ST_TITLE;
      level_sel     <= '0;
      hold_cnt      <= '0;
      level_reset_n <= '0;
      hold_active   <= 1'b0;
    end else begin
      state         <= state_d;
      level_sel     <= level_sel_d;
      hold_cnt      <= hold_cnt_d;
      level_reset_n <= level_reset_n_d;
      hold_active   <= is_hold(state_d);
    end
  end

`ifdef GAME_LIVES_EN
  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) lives <= 3'(START_LIVES);
    else        lives <= lives_d;
  end
`else
  assign lives = 3'd0;
`endif

  assign game_state = state;

endmodule

// File: tb/tb_game_flow_controller.sv
// Bench for game_flow_controller: screen-level reference model checked every cycle plus directed literal checks.
module tb_game_flow_controller;

  localparam int NUM_LEVELS  = 3;
  localparam int LEVEL_W     = 2;
  localparam int START_LIVES = 3;
  localparam int HOLD_CYCLES = 4;
`ifdef GAME_LIVES_EN
  localparam bit LIVES_EN = 1'b1;
`else
  localparam bit LIVES_EN = 1'b0;
`endif
  localparam int LIVES0 = LIVES_EN ? START_LIVES : 0;

  logic                  vga_clock;
  logic                  reset;
  logic                  start_button;
  logic                  level_win;
  logic                  level_lose;
  logic [NUM_LEVELS-1:0] level_reset_n;
  logic [LEVEL_W-1:0]    level_sel;
  logic [2:0]            game_state;
  logic [2:0]            lives;
  logic                  hold_active;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  game_flow_controller #(
    .NUM_LEVELS  (NUM_LEVELS),
    .LEVEL_W     (LEVEL_W),
    .START_LIVES (START_LIVES),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) dut (
    .vga_clock     (vga_clock),
    .reset         (reset),
    .start_button  (start_button),
    .level_win     (level_win),
    .level_lose    (level_lose),
    .level_reset_n (level_reset_n),
    .level_sel     (level_sel),
    .game_state    (game_state),
    .lives         (lives),
    .hold_active   (hold_active)
  );

  initial vga_clock = 1'b0;
  always #5 vga_clock = ~vga_clock;

  // Screen-level model: screen number, live level, lives, cycles left on a result screen,
  // and the last four sampled button levels (a press acts four edges after it is first seen).
  typedef struct {
    int       screen;
    int       lvl;
    int       lives_left;
    int       dwell_left;
    bit [3:0] btn;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t r;
    r.screen = 0; r.lvl = 0; r.lives_left = LIVES0; r.dwell_left = 0; r.btn = '0;
    return r;
  endfunction

  function automatic model_t model_step(input model_t c, input bit b, input bit w, input bit l);
    model_t n = c;
    bit press = c.btn[2] && !c.btn[3];
    n.btn = {c.btn[2:0], b};
    case (c.screen)
      0: if (press) n.screen = 1;
      1: begin
        if (w) begin
          n.screen = 2; n.dwell_left = HOLD_CYCLES;
        end else if (l) begin
          n.screen = 3; n.dwell_left = HOLD_CYCLES;
          if (LIVES_EN && c.lives_left > 0) n.lives_left = c.lives_left - 1;
        end
      end
      2: begin
        n.dwell_left = c.dwell_left - 1;
        if (n.dwell_left == 0) begin
          if (c.lvl == NUM_LEVELS - 1) n.screen = 5;
          else begin n.screen = 1; n.lvl = c.lvl + 1; end
        end
      end
      3: begin
        n.dwell_left = c.dwell_left - 1;
        if (n.dwell_left == 0) n.screen = (LIVES_EN && c.lives_left > 0) ? 0 : 4;
      end
      default: if (press) begin n.screen = 0; n.lvl = 0; n.lives_left = LIVES0; end
    endcase
    return n;
  endfunction

  always @(posedge vga_clock or negedge reset) begin
    if (!reset) m <= model_reset();
    else        m <= model_step(m, start_button, level_win, level_lose);
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge vga_clock) begin
    if (chk_en) begin
      check("model game_state",    int'(game_state),    m.screen);
      check("model level_sel",     int'(level_sel),     m.lvl);
      check("model lives",         int'(lives),         m.lives_left);
      check("model level_reset_n", int'(level_reset_n), (m.screen == 1) ? (1 << m.lvl) : 0);
      check("model hold_active",   int'(hold_active),   int'(m.screen == 2 || m.screen == 3));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge vga_clock);
  endtask

  // Press for hold_n cycles (1..4) and return exactly four edges after the press began
  task automatic press(input int hold_n);
    start_button = 1'b1;
    tick(hold_n);
    start_button = 1'b0;
    tick(4 - hold_n);
  endtask

  task automatic pulse_win();
    level_win = 1'b1; tick(1); level_win = 1'b0;
  endtask

  task automatic pulse_lose();
    level_lose = 1'b1; tick(1); level_lose = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start_button = 1'b0; level_win = 1'b0; level_lose = 1'b0;
    tick(3);
    chk_en = 1'b1;
    check("reset game_state", int'(game_state), 0);
    check("reset level_reset_n", int'(level_reset_n), 0);
    check("reset lives", int'(lives), LIVES0);
    reset = 1'b1;
    tick(2);

    // Held start: PLAY on the fourth edge, not earlier
    start_button = 1'b1;
    tick(3);
    check("start latency pre", int'(game_state), 0);
    tick(1);
    check("start play", int'(game_state), 1);
    check("start lrn", int'(level_reset_n), 3'b001);
    check("start lives", int'(lives), LIVES0);
    tick(6);
    start_button = 1'b0;
    tick(2);

    // Win on level 0: exactly four cycles of hold
    pulse_win();
    check("win hold state", int'(game_state), 2);
    check("win hold lrn", int'(level_reset_n), 0);
    check("win hold active", int'(hold_active), 1);
    tick(3);
    check("win hold dwell", int'(game_state), 2);
    tick(1);
    check("win next play", int'(game_state), 1);
    check("win next sel", int'(level_sel), 1);
    check("win next lrn", int'(level_reset_n), 3'b010);

    // Levels 1 and 2 complete the game
    tick(2); pulse_win(); tick(4);
    check("level 2 sel", int'(level_sel), 2);
    tick(1); pulse_win(); tick(4);
    check("complete state", int'(game_state), 5);
    press(1);
    check("complete->title", int'(game_state), 0);
    check("complete->title sel", int'(level_sel), 0);

    // Reach level 1 and lose there
    press(2); pulse_win(); tick(4);
`ifdef GAME_LIVES_EN
    for (int k = 0; k < 2; k++) begin
      pulse_lose();
      check("lose lives", int'(lives), 2 - k);
      tick(4);
      check("lose->title", int'(game_state), 0);
      check("lose keeps sel", int'(level_sel), 1);
      press(1);
      check("retry lrn", int'(level_reset_n), 3'b010);
    end
    pulse_lose();
    check("last life", int'(lives), 0);
    tick(4);
    check("game over", int'(game_state), 4);
`else
    pulse_lose();
    check("lose no-lives state", int'(game_state), 3);
    tick(4);
    check("game over first lose", int'(game_state), 4);
    check("game over lives", int'(lives), 0);
`endif
    press(1);
    check("gameover->title", int'(game_state), 0);
    check("gameover->title lives", int'(lives), LIVES0);

    // Win and lose together: ignored in TITLE, win priority in PLAY
    level_win = 1'b1; level_lose = 1'b1; tick(2);
    level_win = 1'b0; level_lose = 1'b0;
    check("title ignores flags", int'(game_state), 0);
    press(1);
    level_win = 1'b1; level_lose = 1'b1; tick(1);
    level_win = 1'b0; level_lose = 1'b0;
    check("both -> win hold", int'(game_state), 2);
    check("both lives kept", int'(lives), LIVES0);
    tick(4);

    // Reset asserted mid-hold on level 1
    pulse_win(); tick(1);
    #2 reset = 1'b0;
    #1;
    check("async reset state", int'(game_state), 0);
    check("async reset sel", int'(level_sel), 0);
    check("async reset lrn", int'(level_reset_n), 0);
    check("async reset hold", int'(hold_active), 0);
    tick(3);
    reset = 1'b1;
    tick(3);
    check("post reset title", int'(game_state), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/game_flow_controller.md
# game_flow_controller

Top-level sequencer for the game. It selects which level instance is live and holds every non-live level in reset. It watches the live level's `win`/`lose` flags, counts lives, and steps through title, play, result-hold and end screens. It sits between the board inputs and the level instances, and drives the level-select mux that feeds the VGA outputs.

## Interface
- `NUM_LEVELS`, default 3: number of level instances; the legal index range is 0..NUM_LEVELS-1.
- `LEVEL_W`, default 2: width of `level_sel`; must satisfy 2^LEVEL_W ≥ NUM_LEVELS.
- `START_LIVES`, default 3: lives loaded at reset and at each new game; range 1..7.
- `HOLD_CYCLES`, default 50_000_000: result-screen duration in vga_clock cycles (2 s at 25 MHz); must be ≥ 1.
- Reset and clock (already decided): reset `reset`, asynchronous, active-low; clock `vga_clock`.
- `vga_clock` in 1: pixel clock; all state is updated on its rising edge.
- `reset` in 1: asynchronous, active-low.
- `start_button` in 1: raw board button, active-high, asynchronous to vga_clock.
- `level_win` in 1: `win` of the level currently selected by `level_sel`, muxed externally.
- `level_lose` in 1: `lose` of the level currently selected by `level_sel`, muxed externally.
- `level_reset_n` out NUM_LEVELS: per-level active-low reset, registered.
- `level_sel` out LEVEL_W: index of the live level; drives the VGA mux.
- `game_state` out 3: encoded FSM state, used by the overlay renderer.
- `lives` out 3: remaining lives.
- `hold_active` out 1: high while in WIN_HOLD or LOSE_HOLD.

## Operation
- Encoding of `game_state`: TITLE=0, PLAY=1, WIN_HOLD=2, LOSE_HOLD=3, GAME_OVER=4, COMPLETE=5.
- `start_button` passes through a 2-flop synchronizer, then a rising-edge detector, producing a 1-cycle `start_pulse`.
- TITLE:
  - `start_pulse` → PLAY.
  - `level_sel` keeps its current value: 0 after reset, or the retry level after a lost life.
- PLAY:
  - Only this state samples `level_win` and `level_lose`.
  - `level_win` → WIN_HOLD, regardless of `level_lose`. Win has priority on the simultaneous case.
  - `level_lose` alone → LOSE_HOLD.
  - `start_pulse` is ignored.
- WIN_HOLD: the hold counter expires, then:
  - if `level_sel` == NUM_LEVELS-1 → COMPLETE;
  - otherwise `level_sel`+1 → PLAY.
- LOSE_HOLD: `lives` decrements by 1 on entry. When the hold counter expires:
  - `lives` == 0 → GAME_OVER;
  - otherwise → TITLE, with `level_sel` unchanged.
- GAME_OVER and COMPLETE: `start_pulse` → TITLE, with `level_sel`=0 and `lives`=START_LIVES.
- Hold counter:
  - Loads HOLD_CYCLES-1 on entry to either hold state.
  - Decrements each cycle and expires in the cycle it reads 0.
  - Total dwell in a hold state is exactly HOLD_CYCLES cycles.
- `level_reset_n[i]` is 1 only when state==PLAY and i==`level_sel`. All other bits are 0.
  - Every level therefore restarts clean (coins, timer, positions) on each entry to PLAY.
- `lives` saturates at 0 and never wraps.
- `level_sel` never exceeds NUM_LEVELS-1.
- Reset values:
  - state TITLE (`game_state`=0), `level_sel`=0, `lives`=START_LIVES.
  - `level_reset_n`=all 0, `hold_active`=0.
  - hold counter 0, synchronizer flops 0.
- Reset asserted mid-game returns all outputs to their reset values asynchronously. The FSM stays in TITLE until reset deasserts.

## Timing
- Button latency: `start_button` rising → `start_pulse` on the 3rd edge → `game_state`=PLAY and the selected `level_reset_n` bit high on the 4th edge.
- A held button produces exactly one `start_pulse`.
- `level_win`/`level_lose` high in PLAY at edge N:
  - at edge N, state becomes the hold state and `hold_active`=1;
  - at edge N, the live `level_reset_n` bit drops (registered, same edge).
- Hold exit lands on edge N+HOLD_CYCLES. `level_sel` updates on that same edge.
- Entering PLAY: `level_sel` and `level_reset_n` change on the same edge, so no cycle ever releases a mismatched level.

## Configuration
- `GAME_LIVES_EN` defined:
  - lives behaviour as described above;
  - `lives` output is live.
- `GAME_LIVES_EN` undefined:
  - the lives register is removed and `lives` is tied to 0;
  - LOSE_HOLD expiry always → GAME_OVER.

## Structure
- Shared package `game_pkg` holds:
  - `game_state_t`, a 3-bit enum with the encodings above;
  - level-count and hold-time defaults.
- The VGA overlay and LED logic import this enum rather than redeclaring it.
- One sub-module, `button_sync_edge`: 2-flop synchronizer plus rising-edge pulse, with async active-low reset. It is reused for the jump button elsewhere.
- FSM, hold counter, lives and level index stay in `game_flow_controller`.

## Test plan
All scenarios use HOLD_CYCLES=4, NUM_LEVELS=3, START_LIVES=3 unless noted.
- Reset, then press start for 10 cycles → one PLAY entry 4 edges after the press; `level_reset_n`=3'b001; `lives`=3.
- PLAY on level 0, pulse `level_win` one cycle → WIN_HOLD for exactly 4 cycles, then PLAY with `level_sel`=1 and `level_reset_n`=3'b010.
- Win on levels 0, 1 and 2 → COMPLETE after the third hold; start → TITLE with `level_sel`=0.
- Three `level_lose` events on level 1 → `lives` goes 2, 1, 0; TITLE twice with `level_sel`=1 retained; then GAME_OVER.
- `level_win` and `level_lose` both asserted in the same PLAY cycle → WIN_HOLD and `lives` unchanged. Both asserted during TITLE → ignored.
- Assert reset during WIN_HOLD → immediate TITLE, `level_sel`=0, `level_reset_n`=0. A second build without `GAME_LIVES_EN`: first lose → GAME_OVER, `lives`=0.
